// File: rtl/lgn_frame_loader_if.sv
// ----------------------------------------------------------------------------
// lgn_frame_loader_if
// Bundles the three buses of the LGN frame loader:
//   pixel stream : pix_data, pix_valid (to loader), pix_ready (from loader)
//   classifier   : lgn_data, lgn_we (to classifier), lgn_result (from it)
//   result       : res_valid, res_seg, res_score, res_class, res_err (from
//                  loader), res_ready (to loader)
// modport slave  : the loader's view
// modport master : the environment's view (pixel source, classifier, sink)
// ----------------------------------------------------------------------------
interface lgn_frame_loader_if;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  lgn_data;
    logic        lgn_we;
    logic [15:0] lgn_result;
    logic        res_valid;
    logic        res_ready;
    logic [6:0]  res_seg;
    logic [7:0]  res_score;
    logic [3:0]  res_class;
    logic        res_err;

    modport slave (
        input  pix_data, pix_valid, lgn_result, res_ready,
        output pix_ready, lgn_data, lgn_we,
               res_valid, res_seg, res_score, res_class, res_err
    );

    modport master (
        output pix_data, pix_valid, lgn_result, res_ready,
        input  pix_ready, lgn_data, lgn_we,
               res_valid, res_seg, res_score, res_class, res_err
    );
endinterface

// File: rtl/lgn_frame_loader.sv
// ----------------------------------------------------------------------------
// lgn_frame_loader
// Accepts a 16x16 grayscale frame (256 pixels, raster order), binarizes each
// pixel into a 4-bit thermometer nibble against THR0..THR3, packs pixel pairs
// into bytes and writes the 128 bytes into the classifier's input shift
// register (byte 0 first). After SETTLE_CYCLES it captures the classifier
// result and presents it on a valid/ready result port.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : lgn_frame_loader_if.slave (pixel stream, classifier bus, result)
//
// Optional build macro LGN_FRAME_LOADER_DECODE_EN: when defined, the captured
// seven-segment pattern is decoded into res_class / res_err; otherwise both
// outputs are constant 0.
// ----------------------------------------------------------------------------
module lgn_frame_loader #(
    parameter int         SETTLE_CYCLES = 4,
    parameter logic [7:0] THR0          = 8'd51,
    parameter logic [7:0] THR1          = 8'd102,
    parameter logic [7:0] THR2          = 8'd153,
    parameter logic [7:0] THR3          = 8'd204
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lgn_frame_loader_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RESULT} state_t;

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    state_t          state_q, state_d;
    logic [6:0]      cnt_q, cnt_d;        // bytes written in this frame
    logic            par_q, par_d;        // 1 = even nibble held, waiting odd
    logic [3:0]      nib_q, nib_d;
    logic            last_q, last_d;      // byte 127 written, lgn_we in flight
    logic [SW-1:0]   set_q, set_d;
    logic [7:0]      data_q, data_d;
    logic            we_q, we_d;
    logic [6:0]      seg_q, seg_d;
    logic [7:0]      score_q, score_d;
    logic            pix_ready_c;
    logic            unused_seg_bit7;

    assign unused_seg_bit7 = bus.lgn_result[7];

    function automatic logic [3:0] to_nibble(input logic [7:0] p);
        return {p > THR3, p > THR2, p > THR1, p > THR0};
    endfunction

`ifdef LGN_FRAME_LOADER_DECODE_EN
    logic [3:0] class_q, class_d;
    logic       err_q, err_d;

    // Returns {err, class}; anything that is not a clean digit flags an error.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F:   return 5'b0_0000;
            7'h06:   return 5'b0_0001;
            7'h5B:   return 5'b0_0010;
            7'h4F:   return 5'b0_0011;
            7'h66:   return 5'b0_0100;
            7'h6D:   return 5'b0_0101;
            7'h7C:   return 5'b0_0110;
            7'h07:   return 5'b0_0111;
            7'h7F:   return 5'b0_1000;
            7'h67:   return 5'b0_1001;
            default: return 5'b1_1111;
        endcase
    endfunction
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        par_d       = par_q;
        nib_d       = nib_q;
        last_d      = last_q;
        set_d       = set_q;
        data_d      = data_q;
        we_d        = 1'b0;
        seg_d       = seg_q;
        score_d     = score_q;
        pix_ready_c = 1'b0;
`ifdef LGN_FRAME_LOADER_DECODE_EN
        class_d     = class_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE, LOAD: begin
                // Stall input while the final byte's strobe is still out, so
                // no 257th pixel can slip in before SETTLE.
                pix_ready_c = rst_n && !last_q;
                if (pix_ready_c && bus.pix_valid) begin
                    state_d = LOAD;
                    if (!par_q) begin
                        nib_d = to_nibble(bus.pix_data);
                        par_d = 1'b1;
                    end else begin
                        par_d  = 1'b0;
                        data_d = {nib_q, to_nibble(bus.pix_data)};
                        we_d   = 1'b1;
                        cnt_d  = cnt_q + 7'd1;
                        if (cnt_q == 7'd127) begin
                            last_d = 1'b1;
                        end
                    end
                end
                if (state_q == LOAD && last_q) begin
                    state_d = SETTLE;
                    last_d  = 1'b0;
                    set_d   = '0;
                end
            end
            SETTLE: begin
                if (set_q == SETTLE_LAST) begin
                    seg_d   = bus.lgn_result[6:0];
                    score_d = bus.lgn_result[15:8];
`ifdef LGN_FRAME_LOADER_DECODE_EN
                    {err_d, class_d} = decode(bus.lgn_result[6:0]);
`endif
                    state_d = RESULT;
                end else begin
                    set_d = set_q + 1'b1;
                end
            end
            RESULT: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            nib_q   <= '0;
            last_q  <= 1'b0;
            set_q   <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            seg_q   <= '0;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            nib_q   <= nib_d;
            last_q  <= last_d;
            set_q   <= set_d;
            data_q  <= data_d;
            we_q    <= we_d;
            seg_q   <= seg_d;
            score_q <= score_d;
        end
    end

`ifdef LGN_FRAME_LOADER_DECODE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            class_q <= '0;
            err_q   <= 1'b0;
        end else begin
            class_q <= class_d;
            err_q   <= err_d;
        end
    end

    assign bus.res_class = class_q;
    assign bus.res_err   = err_q;
`else
    assign bus.res_class = 4'd0;
    assign bus.res_err   = 1'b0;
`endif

    assign bus.pix_ready = pix_ready_c;
    assign bus.lgn_data  = data_q;
    assign bus.lgn_we    = we_q;
    assign bus.res_valid = (state_q == RESULT);
    assign bus.res_seg   = seg_q;
    assign bus.res_score = score_q;

endmodule

// File: tb/tb_lgn_frame_loader.sv
// ----------------------------------------------------------------------------
// tb_lgn_frame_loader
// Scoreboard bench for lgn_frame_loader: the stimulus process pushes expected
// classifier bytes and expected results into queues; a monitor on the falling
// edge pops and compares whenever lgn_we or a new res_valid appears.
// ----------------------------------------------------------------------------
module tb_lgn_frame_loader;

    localparam int SETTLE = 4;
`ifdef LGN_FRAME_LOADER_DECODE_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    typedef struct packed {
        logic [6:0] seg;
        logic [7:0] score;
        logic [3:0] cls;
        logic       err;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lgn_frame_loader_if bus();

    lgn_frame_loader #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   tests = 0;
    int   fails = 0;
    logic [7:0] exp_bytes[$];
    res_t       exp_res[$];
    logic [7:0] px[256];
    int   pulses = 0;
    int   cyc = 0;
    int   last_we_cyc = 0;
    logic rv_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Thermometer nibble from the threshold definition (0.2..0.8 of 255).
    function automatic logic [3:0] nib(input logic [7:0] p);
        return {p > 8'd204, p > 8'd153, p > 8'd102, p > 8'd51};
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        cyc++;
        if (rst_n && bus.lgn_we) begin
            pulses++;
            last_we_cyc = cyc;
            if (exp_bytes.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL lgn_we_extra: got pulse %0d, expected no pulse", pulses);
            end else begin
                chk("lgn_data", {24'd0, bus.lgn_data}, {24'd0, exp_bytes.pop_front()});
            end
        end
        if (rst_n && bus.res_valid && !rv_prev) begin
            res_t r;
            chk("we_pulses", pulses, 128);
            chk("settle_latency", cyc - last_we_cyc, SETTLE + 1);
            if (exp_res.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL res_extra: got res_valid, expected none");
            end else begin
                r = exp_res.pop_front();
                chk("res_seg",   {25'd0, bus.res_seg},   {25'd0, r.seg});
                chk("res_score", {24'd0, bus.res_score}, {24'd0, r.score});
                chk("res_class", {28'd0, bus.res_class}, {28'd0, r.cls});
                chk("res_err",   {31'd0, bus.res_err},   {31'd0, r.err});
            end
            pulses = 0;
        end
        rv_prev = bus.res_valid;
    end

    task automatic send_pix(input logic [7:0] d, input int gap);
        bit ok;
        if (gap > 0) begin
            bus.pix_valid = 1'b0;
            bus.pix_data  = ~d;
            repeat (gap) @(posedge clk);
            #1;
        end
        bus.pix_valid = 1'b1;
        bus.pix_data  = d;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.pix_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL pix_ready_timeout: got 0, expected 1");
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_result();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL res_valid_timeout: got 0, expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input bit gaps, input logic [15:0] lres,
                             input logic [3:0] cls, input logic err);
        res_t r;
        bus.lgn_result = lres;
        r.seg   = lres[6:0];
        r.score = lres[15:8];
        r.cls   = DEC ? cls : 4'd0;
        r.err   = DEC ? err : 1'b0;
        exp_res.push_back(r);
        for (int k = 0; k < 128; k++) exp_bytes.push_back({nib(px[2*k]), nib(px[2*k+1])});
        for (int i = 0; i < 256; i++) send_pix(px[i], gaps ? int'($urandom_range(0, 1)) : 0);
        bus.pix_valid = 1'b0;
        wait_result();
    endtask

    task automatic release_result(input logic [6:0] seg);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        chk("res_valid_after_ack", {31'd0, bus.res_valid}, 32'd0);
        chk("pix_ready_after_ack", {31'd0, bus.pix_ready}, 32'd1);
        chk("res_seg_retained",    {25'd0, bus.res_seg},   {25'd0, seg});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.pix_valid  = 1'b0;
        bus.pix_data   = 8'h00;
        bus.res_ready  = 1'b0;
        bus.lgn_result = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pix_ready", {31'd0, bus.pix_ready}, 32'd0);
        chk("rst_lgn_we",    {31'd0, bus.lgn_we},    32'd0);
        chk("rst_lgn_data",  {24'd0, bus.lgn_data},  32'd0);
        chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_res_seg",   {25'd0, bus.res_seg},   32'd0);
        chk("rst_res_score", {24'd0, bus.res_score}, 32'd0);
        chk("rst_res_class", {28'd0, bus.res_class}, 32'd0);
        chk("rst_res_err",   {31'd0, bus.res_err},   32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_pix_ready", {31'd0, bus.pix_ready}, 32'd1);

        // Frame 1: all-zero pixels, result 0x9067, consumer stalls 10 cycles
        for (int i = 0; i < 256; i++) px[i] = 8'h00;
        run_frame(1'b0, 16'h9067, 4'd9, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("hold_res_valid", {31'd0, bus.res_valid}, 32'd1);
            chk("hold_pix_ready", {31'd0, bus.pix_ready}, 32'd0);
            chk("hold_res_seg",   {25'd0, bus.res_seg},   32'h67);
            chk("hold_res_score", {24'd0, bus.res_score}, 32'h90);
            chk("hold_res_class", {28'd0, bus.res_class}, DEC ? 32'd9 : 32'd0);
            @(posedge clk);
            #1;
        end
        release_result(7'h67);

        // Frame 2: threshold vectors 0x80,0xFF,0x33,0x34 -> 0x3F, 0x01; bit 7 of
        // the result must be ignored
        px[0] = 8'h80; px[1] = 8'hFF; px[2] = 8'h33; px[3] = 8'h34;
        for (int i = 4; i < 256; i++) px[i] = 8'(i * 37 + 11);
        run_frame(1'b0, 16'h33BF, 4'd0, 1'b0);
        release_result(7'h3F);

        // Frame 3: same pixels with random pix_valid gaps, invalid pattern
        run_frame(1'b1, 16'h1200, 4'd15, 1'b1);
        release_result(7'h00);

        // Partial frame of 37 pixels, then asynchronous reset
        for (int k = 0; k < 18; k++) exp_bytes.push_back({nib(px[2*k]), nib(px[2*k+1])});
        for (int i = 0; i < 37; i++) send_pix(px[i], 0);
        bus.pix_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_lgn_we",    {31'd0, bus.lgn_we},    32'd0);
        chk("midrst_pix_ready", {31'd0, bus.pix_ready}, 32'd0);
        chk("midrst_res_seg",   {25'd0, bus.res_seg},   32'd0);
        chk("midrst_exp_left",  exp_bytes.size(),       32'd0);
        pulses = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Frame 4 after reset must start at byte 0 (first byte 0xF0)
        px[0] = 8'hFF; px[1] = 8'h00;
        run_frame(1'b0, 16'h7A06, 4'd1, 1'b0);
        release_result(7'h06);
        chk("exp_bytes_drained", exp_bytes.size(), 32'd0);
        chk("exp_res_drained",   exp_res.size(),   32'd0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
